// File: rtl/pipe_stage_if.sv
// Stage-word handshake bundle: valid/ready plus a control field and a payload field.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipe_stage_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with flush-to-bubble and a saturating stall counter.
// in_ready depends only on reset and skid occupancy, so out_ready never reaches it combinationally.
module pipe_stage_reg #(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 16,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_if.slave      up,
    pipe_stage_if.master     dn,
    output logic [CNT_W-1:0] stall_cnt
);

    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic in_hs;
    logic main_load;
    logic stalled;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign up.ready  = rst_n & ~skid_valid;
    assign in_hs     = up.valid & up.ready;
    assign main_load = ~vld_p1 | dn.ready;
    assign stalled   = vld_p1 & ~dn.ready;

    assign dn.valid = vld_p1;
    assign dn.ctrl  = ctrl_p1;
    assign dn.data  = data_p1;

    // Stage boundary: main register feeds the out ports, skid catches the word accepted while main is stuck.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            data_p1    <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            stall_cnt  <= '0;
        end else if (flush) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            if (CLEAR_DATA != 0) begin
                data_p1   <= '0;
                skid_data <= '0;
            end
        end else begin
            if (main_load) begin
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
                if (skid_valid) begin
                    vld_p1  <= 1'b1;
                    ctrl_p1 <= skid_ctrl;
                    data_p1 <= skid_data;
                end else if (in_hs) begin
                    vld_p1  <= 1'b1;
                    ctrl_p1 <= up.ctrl;
                    data_p1 <= up.data;
                end else begin
                    vld_p1  <= 1'b0;
                    ctrl_p1 <= '0;
                end
            end else if (in_hs) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= up.ctrl;
                skid_data  <= up.data;
            end
            if (stalled) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule
